mem_rd_arbiter: RTL and testbench
=================================

Name: mem_rd_arbiter

Overview:
- Session-based arbiter that shares the matrix_mem ALU read port (alu_rd_slot/row/col -> alu_rd_data) among up to N_REQ requesters, e.g. matrix ALU, bonus_conv, display/UART dump.
- A requester holds req for a whole operation and owns the port until it drops req or is preempted by the timeout.
- Round-robin fairness applies between sessions.
- Sits between the requesters and matrix_mem; read data is broadcast to all requesters, and each qualifies it with its own gnt.

Parameters:
- N_REQ, 3, number of requesters; index 0 is the ALU, 1 is bonus_conv, 2 is display.
- TIMEOUT, 1023, maximum cycles a session may hold the port while another req is pending; 0 disables preemption.
- DATA_W, 16, read data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  N_REQ  per-requester session request, level.
- req_slot  in  2*N_REQ  packed slot index; requester i uses bits [2i+1:2i].
- req_row  in  3*N_REQ  packed row; requester i uses bits [3i+2:3i].
- req_col  in  3*N_REQ  packed column; same packing as req_row.
- gnt  out  N_REQ  one-hot or zero; requester i owns the port while gnt[i]=1.
- rd_data  out  DATA_W  mem_rd_data passed through combinationally to all requesters.
- mem_rd_slot  out  2  to matrix_mem alu_rd_slot.
- mem_rd_row  out  3  to matrix_mem alu_rd_row.
- mem_rd_col  out  3  to matrix_mem alu_rd_col.
- mem_rd_data  in  DATA_W  from matrix_mem alu_rd_data; combinational read.
- owner_id  out  2  index of the current owner; valid only while busy=1.
- busy  out  1  1 while in GRANT.
- timeout_err  out  1  one-cycle pulse when a session is preempted.

Behaviour:
- Reset, including mid-session: state=IDLE, gnt=0, busy=0, owner_id=0, timeout_err=0, rr_ptr=0, hold counter=0, preempt mask=0. Memory address outputs are 0.
- States: IDLE, GRANT, RELEASE. All are registered; gnt, busy and owner_id are decoded from registered state only.
- IDLE:
  - eligible = req & ~mask.
  - If eligible is non-zero, pick the first set bit searching upward from rr_ptr, wrapping around.
  - Register owner, clear the counter, go to GRANT.
  - gnt[owner] rises on the clock edge after req was first sampled, i.e. 1 cycle latency.
- GRANT:
  - Address mux: mem_rd_* = req_slot/row/col fields of the owner, combinational from the registered owner.
  - The counter increments each cycle, saturating at TIMEOUT.
  - If req[owner]=0 when sampled: go to RELEASE, set rr_ptr=owner+1 mod N_REQ.
  - Else if TIMEOUT!=0, counter==TIMEOUT, and some other eligible req is set: go to RELEASE, pulse timeout_err in the first RELEASE cycle, set mask[owner]=1, advance rr_ptr as above.
  - A req drop and a timeout on the same edge count as a normal release: no timeout_err, no mask.
- RELEASE:
  - Exactly 1 cycle with gnt=0 and address=0, then go to IDLE.
  - Handoff gap: the owner drops req at edge k, gnt falls at k, the next gnt rises at k+2.
- Mask: mask[i] clears on any cycle where req[i]=0. A preempted requester must deassert req for at least 1 cycle before it is eligible again.
- Outside GRANT: mem_rd_* = 0 and gnt=0.
- rd_data = mem_rd_data at all times, with no register.
- Only the owner's address fields affect the memory. Other requesters' address inputs are don't-care.
- N_REQ=1 is legal: that requester is always the round-robin pick.

Decomposition:
- Shared package holds:
  - requester index constants REQ_ALU=0, REQ_CONV=1, REQ_DISP=2;
  - the state encoding for IDLE/GRANT/RELEASE;
  - address width constants SLOT_W=2, ROW_W=3, COL_W=3.
- One sub-module, rr_pick: combinational round-robin priority encoder. Inputs are the eligible vector and rr_ptr; outputs are found and the chosen index. It is reused by future write-port arbitration.

Test Plan:
- Single requester: req[1] rises at cycle 0 with slot=0, row=2, col=1, and memory holds A[2][1]=7. Expect gnt=3'b010 from cycle 1, mem_rd_row=2, mem_rd_col=1, rd_data=7, busy=1, owner_id=1.
- Simultaneous request from IDLE after reset: req=3'b111. Expect owner 0 first. Drop req[0]: gnt=0 for 2 cycles, then gnt=3'b010. Next session goes to owner 2, then wraps to 0.
- bonus_conv session with a real matrix_mem: load a 3x3 kernel into slot A, hold req[1] for the full run. The conv output stream must be identical to running with no arbiter, and gnt[1] must stay high throughout.
- Timeout with TIMEOUT=8: req[0] held, req[2] raised at cycle 3. Expect gnt[0] to fall after 8 held cycles, timeout_err=1 for exactly 1 cycle, gnt[2] 2 cycles later. With req[0] still high, expect no re-grant to 0 until req[0] has gone low for 1 cycle.
- Reset mid-session: rst=1 while gnt=3'b100. Expect gnt=0, mem_rd_* = 0 and busy=0 after that edge. Expect rr_ptr=0, checked by the next arbitration with req=3'b110 granting owner 1.
- Drop and timeout on the same edge: req[0] falls exactly at counter==TIMEOUT. Expect no timeout_err and mask[0]=0, so an immediate re-request by requester 0 is eligible.

Source files
------------

// File: rtl/mem_rd_arbiter_pkg.sv
// Shared definitions for the matrix_mem read-port arbiter: requester indices,
// FSM state encoding and address field widths.
package mem_rd_arbiter_pkg;

    localparam int REQ_ALU  = 0;
    localparam int REQ_CONV = 1;
    localparam int REQ_DISP = 2;

    localparam int SLOT_W = 2;
    localparam int ROW_W  = 3;
    localparam int COL_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_rd_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set bit of i_eligible
// searching upward from i_ptr, wrapping around.
module mem_rd_arbiter_rr_pick
    import mem_rd_arbiter_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDX_W = idx_width(N_REQ)
)
(
    input  logic [N_REQ-1:0] i_eligible,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            if (i_eligible[(int'(i_ptr) + off) % N_REQ]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'((int'(i_ptr) + off) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Session-based round-robin arbiter sharing the matrix_mem read port among
// N_REQ requesters, with optional timeout preemption of long sessions.
module mem_rd_arbiter
    import mem_rd_arbiter_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 1023,
    parameter int DATA_W  = 16
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [SLOT_W*N_REQ-1:0]   req_slot,
    input  logic [ROW_W*N_REQ-1:0]    req_row,
    input  logic [COL_W*N_REQ-1:0]    req_col,
    output logic [N_REQ-1:0]          gnt,
    output logic [DATA_W-1:0]         rd_data,
    output logic [SLOT_W-1:0]         mem_rd_slot,
    output logic [ROW_W-1:0]          mem_rd_row,
    output logic [COL_W-1:0]          mem_rd_col,
    input  logic [DATA_W-1:0]         mem_rd_data,
    output logic [1:0]                owner_id,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    arb_state_t         r_state;
    arb_state_t         w_state_next;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   w_owner_next;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   w_rr_ptr_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [N_REQ-1:0]   r_mask;
    logic [N_REQ-1:0]   w_mask_next;
    logic               r_timeout_err;
    logic               w_timeout_err_next;

    logic [N_REQ-1:0]   w_eligible;
    logic [N_REQ-1:0]   w_owner_oh;
    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   w_ptr_after_owner;
    logic               w_owner_req;
    logic               w_other_pending;

    logic [SLOT_W-1:0]  w_slot_arr [N_REQ];
    logic [ROW_W-1:0]   w_row_arr  [N_REQ];
    logic [COL_W-1:0]   w_col_arr  [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign w_slot_arr[gi] = req_slot[gi*SLOT_W +: SLOT_W];
        assign w_row_arr[gi]  = req_row[gi*ROW_W +: ROW_W];
        assign w_col_arr[gi]  = req_col[gi*COL_W +: COL_W];
        assign w_owner_oh[gi] = (r_owner == IDX_W'(gi));
    end

    assign w_eligible        = req & ~r_mask;
    assign w_owner_req       = |(req & w_owner_oh);
    assign w_other_pending   = |(w_eligible & ~w_owner_oh);
    assign w_ptr_after_owner = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;

    mem_rd_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_eligible (w_eligible),
        .i_ptr      (r_rr_ptr),
        .o_found    (w_found),
        .o_idx      (w_pick)
    );

    always_comb begin
        w_state_next       = r_state;
        w_owner_next       = r_owner;
        w_rr_ptr_next      = r_rr_ptr;
        w_cnt_next         = r_cnt;
        w_mask_next        = r_mask & req;
        w_timeout_err_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_owner_next = w_pick;
                    w_cnt_next   = '0;
                    w_state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
                // A drop takes precedence over a coincident timeout.
                if (!w_owner_req) begin
                    w_state_next  = ST_RELEASE;
                    w_rr_ptr_next = w_ptr_after_owner;
                end else if ((TIMEOUT != 0) && (r_cnt == CNT_MAX) && w_other_pending) begin
                    w_state_next       = ST_RELEASE;
                    w_rr_ptr_next      = w_ptr_after_owner;
                    w_timeout_err_next = 1'b1;
                    w_mask_next        = w_mask_next | w_owner_oh;
                end
            end
            ST_RELEASE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_owner       <= IDX_W'(REQ_ALU);
            r_rr_ptr      <= '0;
            r_cnt         <= '0;
            r_mask        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_owner       <= w_owner_next;
            r_rr_ptr      <= w_rr_ptr_next;
            r_cnt         <= w_cnt_next;
            r_mask        <= w_mask_next;
            r_timeout_err <= w_timeout_err_next;
        end
    end

    assign busy        = (r_state == ST_GRANT);
    assign gnt         = busy ? w_owner_oh : '0;
    assign owner_id    = 2'(r_owner);
    assign timeout_err = r_timeout_err;
    assign rd_data     = mem_rd_data;
    assign mem_rd_slot = busy ? w_slot_arr[r_owner] : '0;
    assign mem_rd_row  = busy ? w_row_arr[r_owner]  : '0;
    assign mem_rd_col  = busy ? w_col_arr[r_owner]  : '0;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter with a behavioural matrix_mem model and
// TIMEOUT=8 so preemption is reachable quickly.
module tb_mem_rd_arbiter;
    import mem_rd_arbiter_pkg::*;

    localparam int N_REQ   = 3;
    localparam int TIMEOUT = 8;
    localparam int DATA_W  = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req;
    logic [SLOT_W*N_REQ-1:0] req_slot;
    logic [ROW_W*N_REQ-1:0]  req_row;
    logic [COL_W*N_REQ-1:0]  req_col;
    logic [N_REQ-1:0]        gnt;
    logic [DATA_W-1:0]       rd_data;
    logic [SLOT_W-1:0]       mem_rd_slot;
    logic [ROW_W-1:0]        mem_rd_row;
    logic [COL_W-1:0]        mem_rd_col;
    logic [DATA_W-1:0]       mem_rd_data;
    logic [1:0]              owner_id;
    logic                    busy;
    logic                    timeout_err;

    logic [DATA_W-1:0] mem [4][8][8];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_rd_slot][mem_rd_row][mem_rd_col];

    mem_rd_arbiter #(
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT),
        .DATA_W  (DATA_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_slot    (req_slot),
        .req_row     (req_row),
        .req_col     (req_col),
        .gnt         (gnt),
        .rd_data     (rd_data),
        .mem_rd_slot (mem_rd_slot),
        .mem_rd_row  (mem_rd_row),
        .mem_rd_col  (mem_rd_col),
        .mem_rd_data (mem_rd_data),
        .owner_id    (owner_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    function automatic logic [DATA_W-1:0] word_at(input int s, input int r, input int c);
        return DATA_W'(s * 256 + r * 16 + c + 100);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_addr(input int i, input logic [1:0] s, input logic [2:0] r, input logic [2:0] c);
        req_slot[i*SLOT_W +: SLOT_W] = s;
        req_row[i*ROW_W +: ROW_W]    = r;
        req_col[i*COL_W +: COL_W]    = c;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (owner_id !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d exp=0", owner_id); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_terr got=%b exp=0", timeout_err); end
        total++; if ({mem_rd_slot, mem_rd_row, mem_rd_col} !== 8'h00) begin bad++;
            $display("FAIL reset_addr got=%h exp=00", {mem_rd_slot, mem_rd_row, mem_rd_col}); end
        $display("test_reset: gnt=%b busy=%b", gnt, busy);
    endtask

    task automatic test_single();
        set_addr(0, 2'd3, 3'd7, 3'd7);
        set_addr(1, 2'd0, 3'd2, 3'd1);
        set_addr(2, 2'd2, 3'd5, 3'd6);
        req = 3'b010;
        tick();
        total++; if (gnt !== 3'b010) begin bad++; $display("FAIL single_gnt got=%b exp=010", gnt); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
        total++; if (owner_id !== 2'd1) begin bad++; $display("FAIL single_owner got=%0d exp=1", owner_id); end
        total++; if (mem_rd_row !== 3'd2 || mem_rd_col !== 3'd1 || mem_rd_slot !== 2'd0) begin bad++;
            $display("FAIL single_addr got=%0d/%0d/%0d exp=0/2/1", mem_rd_slot, mem_rd_row, mem_rd_col); end
        total++; if (rd_data !== 16'd7) begin bad++; $display("FAIL single_data got=%0d exp=7", rd_data); end
        req = 3'b000;
        tick();
        total++; if (gnt !== 3'b000 || mem_rd_row !== 3'd0) begin bad++;
            $display("FAIL single_release got gnt=%b row=%0d exp gnt=000 row=0", gnt, mem_rd_row); end
        tick();
        tick();
        $display("test_single: owner=%0d data=7", 1);
    endtask

    task automatic test_simultaneous();
        do_reset();
        req = 3'b111;
        tick();
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL simul_first got=%b exp=001", gnt); end
        tick();
        req = 3'b110;
        tick();
        total++; if (gnt !== 3'b000) begin bad++; $display("FAIL simul_gap1 got=%b exp=000", gnt); end
        tick();
        total++; if (gnt !== 3'b000) begin bad++; $display("FAIL simul_gap2 got=%b exp=000", gnt); end
        tick();
        total++; if (gnt !== 3'b010) begin bad++; $display("FAIL simul_second got=%b exp=010", gnt); end
        req = 3'b100;
        tick();
        tick();
        tick();
        total++; if (gnt !== 3'b100) begin bad++; $display("FAIL simul_third got=%b exp=100", gnt); end
        req = 3'b011;
        tick();
        tick();
        tick();
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL simul_wrap got=%b exp=001", gnt); end
        req = 3'b000;
        tick();
        tick();
        $display("test_simultaneous: order 0,1,2,0");
    endtask

    task automatic test_conv_session();
        set_addr(0, 2'd3, 3'd7, 3'd7);
        set_addr(2, 2'd2, 3'd5, 3'd6);
        set_addr(1, 2'd1, 3'd0, 3'd0);
        req = 3'b010;
        tick();
        for (int k = 0; k < 12; k++) begin
            set_addr(1, 2'd1, 3'(k / 3), 3'(k % 3));
            #1;
            total++; if (gnt !== 3'b010) begin bad++; $display("FAIL conv_gnt k=%0d got=%b exp=010", k, gnt); end
            total++; if (rd_data !== word_at(1, k / 3, k % 3)) begin bad++;
                $display("FAIL conv_data k=%0d got=%0d exp=%0d", k, rd_data, word_at(1, k / 3, k % 3)); end
            tick();
        end
        req = 3'b000;
        tick();
        tick();
        $display("test_conv_session: 12 reads under one grant");
    endtask

    task automatic test_timeout();
        do_reset();
        req = 3'b001;
        tick();
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL to_grant0 got=%b exp=001", gnt); end
        for (int e = 2; e <= 9; e++) begin
            tick();
            if (e == 3) req = 3'b101;
            total++; if (gnt !== 3'b001 || timeout_err !== 1'b0) begin bad++;
                $display("FAIL to_hold edge=%0d got gnt=%b terr=%b exp gnt=001 terr=0", e, gnt, timeout_err); end
        end
        tick();
        total++; if (gnt !== 3'b000 || timeout_err !== 1'b1) begin bad++;
            $display("FAIL to_preempt got gnt=%b terr=%b exp gnt=000 terr=1", gnt, timeout_err); end
        tick();
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_pulse got=%b exp=0", timeout_err); end
        tick();
        total++; if (gnt !== 3'b100 || owner_id !== 2'd2) begin bad++;
            $display("FAIL to_next got gnt=%b owner=%0d exp gnt=100 owner=2", gnt, owner_id); end
        req = 3'b001;
        tick();
        for (int e = 14; e <= 16; e++) begin
            tick();
            total++; if (gnt !== 3'b000) begin bad++; $display("FAIL to_masked edge=%0d got=%b exp=000", e, gnt); end
        end
        req = 3'b000;
        tick();
        req = 3'b001;
        tick();
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL to_regrant got=%b exp=001", gnt); end
        req = 3'b000;
        tick();
        tick();
        $display("test_timeout: preempt after %0d, regrant after drop", TIMEOUT);
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 3'b010;
        tick();
        req = 3'b000;
        tick();
        tick();
        set_addr(2, 2'd3, 3'd6, 3'd5);
        req = 3'b100;
        tick();
        total++; if (gnt !== 3'b100 || mem_rd_row !== 3'd6) begin bad++;
            $display("FAIL rmid_pre got gnt=%b row=%0d exp gnt=100 row=6", gnt, mem_rd_row); end
        rst = 1'b1;
        tick();
        total++; if (gnt !== 3'b000 || busy !== 1'b0) begin bad++;
            $display("FAIL rmid_gnt got gnt=%b busy=%b exp gnt=000 busy=0", gnt, busy); end
        total++; if ({mem_rd_slot, mem_rd_row, mem_rd_col} !== 8'h00) begin bad++;
            $display("FAIL rmid_addr got=%h exp=00", {mem_rd_slot, mem_rd_row, mem_rd_col}); end
        rst = 1'b0;
        req = 3'b110;
        tick();
        total++; if (gnt !== 3'b010 || owner_id !== 2'd1) begin bad++;
            $display("FAIL rmid_ptr got gnt=%b owner=%0d exp gnt=010 owner=1", gnt, owner_id); end
        req = 3'b000;
        tick();
        tick();
        $display("test_reset_mid: rr_ptr back to 0");
    endtask

    task automatic test_drop_at_timeout();
        do_reset();
        req = 3'b011;
        tick();
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL dt_grant got=%b exp=001", gnt); end
        for (int e = 2; e <= 9; e++) tick();
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL dt_hold got=%b exp=001", gnt); end
        req = 3'b010;
        tick();
        total++; if (gnt !== 3'b000 || timeout_err !== 1'b0) begin bad++;
            $display("FAIL dt_release got gnt=%b terr=%b exp gnt=000 terr=0", gnt, timeout_err); end
        req = 3'b001;
        tick();
        tick();
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL dt_unmasked got=%b exp=001", gnt); end
        req = 3'b000;
        tick();
        tick();
        $display("test_drop_at_timeout: no error, no mask");
    endtask

    initial begin
        for (int s = 0; s < 4; s++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    mem[s][r][c] = word_at(s, r, c);
        mem[0][2][1] = 16'd7;
        rst      = 1'b1;
        req      = '0;
        req_slot = '0;
        req_row  = '0;
        req_col  = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_conv_session();
        test_timeout();
        test_reset_mid();
        test_drop_at_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
